opl_stereo_mixer: RTL and testbench
===================================

# opl_stereo_mixer

Parametrised successor to the mono channel accumulator. Sums NUM_CHANNELS two-operator channels into separately clamped left and right samples. Per-channel connection and pan bits come from the C0–C8 register writes. It sits between the operator pipeline, which writes operator outputs, and the DAC prep stage, which consumes `sample_l`, `sample_r` and `sample_valid`. It produces one stereo sample per `ops_done_pulse`.

## Interface
- NUM_CHANNELS, 9, channel count; multiple of 3, 3..18
- OP_OUT_WIDTH, 13, signed operator output width
- SAMPLE_WIDTH, 16, signed output sample width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_clk_en  in  1  sample-period strobe; aborts any run in progress
- reg_wr_valid  in  1  register write strobe
- reg_wr_address  in  8  register address
- reg_wr_data  in  8  register data
- op_valid  in  1  operator output write strobe
- op_num  in  $clog2(2*NUM_CHANNELS)  operator index
- op_out  in  OP_OUT_WIDTH  signed operator output
- ops_done_pulse  in  1  all operators for this sample have been written
- sample_l, sample_r  out  SAMPLE_WIDTH  clamped signed samples
- clip_l, clip_r  out  1  clamp occurred in the last sample
- sample_valid  out  1  one-cycle pulse; outputs updated
- busy  out  1  high in any state except IDLE

## Operation
- Operator store:
  - NUM_CHANNELS*2 entries, reset to 0.
  - Write port: `op_valid`/`op_num`/`op_out`.
  - Read latency 1. A read of the address being written in the same cycle returns the old data.
- Channel registers, one per channel, written at address C0h+ch when ch < NUM_CHANNELS:
  - cnt = data[0]
  - panL = data[4]
  - panR = data[5]
  - Reset values: cnt=0, panL=1, panR=1.
- Rhythm flag: BDh data[5], reset 0.
- Operator mapping for channel c: first = 6*(c/3) + c%3; second = first + 3.
- FSM states: IDLE, RD_SECOND, RD_FIRST, ACCUM, DONE.
  - IDLE → RD_SECOND on `ops_done_pulse`. acc_l and acc_r are already 0.
  - RD_SECOND: read the second operator → RD_FIRST.
  - RD_FIRST: latch the second operator's output; read the first operator → ACCUM.
  - ACCUM:
    - contrib = cnt ? first+second : second.
    - acc_l += 2*contrib if panL; acc_r += 2*contrib if panR.
    - Then the next channel → RD_SECOND, or DONE after the last channel.
  - DONE: clamp both accumulators, register the outputs, pulse `sample_valid`, clear the accumulators → IDLE.
- Accumulator width: OP_OUT_WIDTH + $clog2(NUM_CHANNELS) + 3, signed; never overflows.
- Clamp range: [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]. clip_x=1 exactly when that side's accumulator was clamped.
- Register writes take effect for every channel whose ACCUM state has not yet occurred.

## Timing
- Reset: all outputs 0, FSM IDLE, accumulators 0, store and registers at their reset values.
- Latency: `ops_done_pulse` in IDLE at cycle T → `sample_valid` high in cycle T+3*NUM_CHANNELS+2 (T+29 for 9 channels). Each channel takes 3 cycles.
- `sample_clk_en` has priority over everything:
  - FSM → IDLE and accumulators → 0 on the next edge.
  - An aborted run produces no `sample_valid`; outputs hold their previous values.
  - `ops_done_pulse` in the same cycle as `sample_clk_en` is ignored.
- `ops_done_pulse` while busy is ignored.
- Outputs hold their values between `sample_valid` pulses.
- Asynchronous reset mid-run: immediate return to reset values; no pulse.

## Configuration
- OPL_MIXER_RHYTHM_EN defined, and the rhythm flag is 1:
  - Channel 6 contrib = 2*second.
  - Channels 7 and 8 contrib = 2*(first+second), regardless of cnt.
  - All other channels are unaffected.
- OPL_MIXER_RHYTHM_EN undefined:
  - The BDh write is ignored and the rhythm logic is not built.
  - All channels use the normal cnt rule.

## Test plan
- Ch0 op0=100, op3=200, all other operators 0, C0h=30h (cnt=0): ops_done → sample_l=sample_r=400, clip=0, `sample_valid` exactly at T+29.
- Same operators, C0h=11h (cnt=1, left only) → sample_l=600, sample_r=0.
- All 18 operators=4095 and all C0–C8=31h → both samples 32767, clip_l=clip_r=1. All operators=-4096 → both -32768, clips 1.
- Rhythm: C6h=30h, op12=100, op15=50, BDh=20h → 200 with OPL_MIXER_RHYTHM_EN defined, 100 without.
- `sample_clk_en` asserted at T+10 → no `sample_valid`, outputs unchanged. The next `ops_done_pulse` yields the correct full sum.
- `reset` asserted at T+15 → all outputs 0 immediately, busy=0. After release, pan defaults to 1/1 (400 on both sides for the first scenario's operator values).

Source files
------------

// File: rtl/opl_stereo_mixer_if.sv
// Bus bundle for opl_stereo_mixer: register writes, operator writes, sample
// strobes and the clamped stereo output.
interface opl_stereo_mixer_if #(
  parameter int NUM_CHANNELS = 9,
  parameter int OP_OUT_WIDTH = 13,
  parameter int SAMPLE_WIDTH = 16
);
  localparam int OP_W = $clog2(2 * NUM_CHANNELS);

  // Strobes are single-cycle: each write/pulse is taken on the edge where it
  // is high; there is no ready, the mixer accepts every write unconditionally.
  logic                           sample_clk_en;
  logic                           reg_wr_valid;
  logic [7:0]                     reg_wr_address;
  logic [7:0]                     reg_wr_data;
  logic                           op_valid;
  logic [OP_W-1:0]                op_num;
  logic signed [OP_OUT_WIDTH-1:0] op_out;
  logic                           ops_done_pulse;
  logic signed [SAMPLE_WIDTH-1:0] sample_l;
  logic signed [SAMPLE_WIDTH-1:0] sample_r;
  logic                           clip_l;
  logic                           clip_r;
  logic                           sample_valid;
  logic                           busy;
  logic [2:0]                     state_dbg;

  modport master (
    output sample_clk_en, reg_wr_valid, reg_wr_address, reg_wr_data,
           op_valid, op_num, op_out, ops_done_pulse,
    input  sample_l, sample_r, clip_l, clip_r, sample_valid, busy, state_dbg
  );

  modport slave (
    input  sample_clk_en, reg_wr_valid, reg_wr_address, reg_wr_data,
           op_valid, op_num, op_out, ops_done_pulse,
    output sample_l, sample_r, clip_l, clip_r, sample_valid, busy, state_dbg
  );
endinterface

// File: rtl/opl_stereo_mixer.sv
// Stereo channel mixer: sums two-operator channels into clamped L/R samples.
// Optional rhythm-mode contribution rules are built when OPL_MIXER_RHYTHM_EN is defined.
module opl_stereo_mixer #(
  parameter int NUM_CHANNELS = 9,
  parameter int OP_OUT_WIDTH = 13,
  parameter int SAMPLE_WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  opl_stereo_mixer_if.slave bus
);
  localparam int OP_COUNT = 2 * NUM_CHANNELS;
  localparam int OP_W     = $clog2(OP_COUNT);
  localparam int CH_W     = $clog2(NUM_CHANNELS);
  localparam int ACC_W    = OP_OUT_WIDTH + $clog2(NUM_CHANNELS) + 3;
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - ACC_W'(1);

  typedef enum logic [2:0] {IDLE, RD_SECOND, RD_FIRST, ACCUM, DONE} state_t;

  state_t                         state;
  logic [CH_W-1:0]                ch;
  logic signed [OP_OUT_WIDTH-1:0] op_mem [OP_COUNT];
  logic signed [OP_OUT_WIDTH-1:0] rd_q;
  logic signed [OP_OUT_WIDTH-1:0] second_q;
  logic [OP_W-1:0]                first_idx, second_idx, rd_addr;
  logic [NUM_CHANNELS-1:0]        cnt_r, pan_l_r, pan_r_r;
  logic signed [ACC_W-1:0]        acc_l, acc_r;
  logic signed [ACC_W-1:0]        first_x, second_x, pair_sum, contrib, contrib2;
  logic [7:0]                     wr_ch;
  logic                           unused_bits;

  assign unused_bits   = ^{bus.reg_wr_data[7:6], bus.reg_wr_data[3:1]};
  assign bus.busy      = (state != IDLE);
  assign bus.state_dbg = state;

  // Channels are laid out in groups of three with the second operators three slots on.
  assign first_idx  = OP_W'(6 * (int'(ch) / 3) + int'(ch) % 3);
  assign second_idx = first_idx + OP_W'(3);
  assign rd_addr    = (state == RD_SECOND) ? second_idx : first_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OP_COUNT; i++) op_mem[i] <= '0;
      rd_q <= '0;
    end else begin
      if (bus.op_valid && int'(bus.op_num) < OP_COUNT) op_mem[bus.op_num] <= bus.op_out;
      rd_q <= op_mem[rd_addr];
    end
  end

  assign wr_ch = bus.reg_wr_address - 8'hC0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      pan_l_r <= '1;
      pan_r_r <= '1;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (bus.reg_wr_valid && bus.reg_wr_address >= 8'hC0 && wr_ch == 8'(i)) begin
          cnt_r[i]   <= bus.reg_wr_data[0];
          pan_l_r[i] <= bus.reg_wr_data[4];
          pan_r_r[i] <= bus.reg_wr_data[5];
        end
      end
    end
  end

`ifdef OPL_MIXER_RHYTHM_EN
  logic rhythm_r;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rhythm_r <= 1'b0;
    else if (bus.reg_wr_valid && bus.reg_wr_address == 8'hBD) rhythm_r <= bus.reg_wr_data[5];
  end
`endif

  always_comb begin
    first_x  = {{(ACC_W-OP_OUT_WIDTH){rd_q[OP_OUT_WIDTH-1]}}, rd_q};
    second_x = {{(ACC_W-OP_OUT_WIDTH){second_q[OP_OUT_WIDTH-1]}}, second_q};
    pair_sum = first_x + second_x;
    contrib  = cnt_r[ch] ? pair_sum : second_x;
`ifdef OPL_MIXER_RHYTHM_EN
    if (rhythm_r) begin
      if (int'(ch) == 6)                          contrib = second_x + second_x;
      else if (int'(ch) == 7 || int'(ch) == 8)    contrib = pair_sum + pair_sum;
    end
`endif
    contrib2 = contrib + contrib;
  end

  function automatic logic [SAMPLE_WIDTH:0] clamp(input logic signed [ACC_W-1:0] a);
    if (a > S_MAX)      return {1'b1, SAMPLE_WIDTH'(S_MAX)};
    else if (a < S_MIN) return {1'b1, SAMPLE_WIDTH'(S_MIN)};
    else                return {1'b0, SAMPLE_WIDTH'(a)};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      ch               <= '0;
      second_q         <= '0;
      acc_l            <= '0;
      acc_r            <= '0;
      bus.sample_l     <= '0;
      bus.sample_r     <= '0;
      bus.clip_l       <= 1'b0;
      bus.clip_r       <= 1'b0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      if (bus.sample_clk_en) begin
        // A new sample period always wins: drop any partial sum silently.
        state <= IDLE;
        ch    <= '0;
        acc_l <= '0;
        acc_r <= '0;
      end else begin
        case (state)
          IDLE: begin
            ch <= '0;
            if (bus.ops_done_pulse) state <= RD_SECOND;
          end
          RD_SECOND: state <= RD_FIRST;
          RD_FIRST: begin
            second_q <= rd_q;
            state    <= ACCUM;
          end
          ACCUM: begin
            if (pan_l_r[ch]) acc_l <= acc_l + contrib2;
            if (pan_r_r[ch]) acc_r <= acc_r + contrib2;
            if (int'(ch) == NUM_CHANNELS - 1) state <= DONE;
            else begin
              ch    <= ch + CH_W'(1);
              state <= RD_SECOND;
            end
          end
          DONE: begin
            {bus.clip_l, bus.sample_l} <= clamp(acc_l);
            {bus.clip_r, bus.sample_r} <= clamp(acc_r);
            bus.sample_valid           <= 1'b1;
            acc_l                      <= '0;
            acc_r                      <= '0;
            ch                         <= '0;
            state                      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_opl_stereo_mixer.sv
// Directed bench for opl_stereo_mixer: hand-computed sums, clamping, rhythm, abort and reset.
module tb_opl_stereo_mixer;
  localparam int NCH = 9;
  localparam int LAT = 3 * NCH + 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   lat;
  int   seen;
  int   rh_l, rh_r;

  opl_stereo_mixer_if #(.NUM_CHANNELS(NCH), .OP_OUT_WIDTH(13), .SAMPLE_WIDTH(16)) bus ();

  opl_stereo_mixer #(.NUM_CHANNELS(NCH), .OP_OUT_WIDTH(13), .SAMPLE_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    bus.reg_wr_valid = 1'b1; bus.reg_wr_address = addr; bus.reg_wr_data = data;
    @(posedge clk); #1;
    bus.reg_wr_valid = 1'b0;
  endtask

  task automatic write_op(input int num, input int val);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_num = 5'(num); bus.op_out = 13'(val);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic fill_ops(input int val);
    for (int i = 0; i < 2 * NCH; i++) write_op(i, val);
  endtask

  task automatic fill_regs(input logic [7:0] data);
    for (int i = 0; i < NCH; i++) write_reg(8'hC0 + 8'(i), data);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    bus.ops_done_pulse = 1'b1;
    @(posedge clk); #1;
    bus.ops_done_pulse = 1'b0;
  endtask

  // Returns the cycle offset of sample_valid relative to the ops_done cycle.
  task automatic run_sample(output int l);
    pulse_done();
    l = 1;
    while (!bus.sample_valid && l < 200) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic check_out(input string tag, input int el, input int er, input int cl, input int cr);
    check_val({tag, "_l"}, int'(bus.sample_l), el);
    check_val({tag, "_r"}, int'(bus.sample_r), er);
    check_val({tag, "_clip_l"}, int'(bus.clip_l), cl);
    check_val({tag, "_clip_r"}, int'(bus.clip_r), cr);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    bus.sample_clk_en = 1'b0; bus.reg_wr_valid = 1'b0; bus.reg_wr_address = '0;
    bus.reg_wr_data = '0; bus.op_valid = 1'b0; bus.op_num = '0; bus.op_out = '0;
    bus.ops_done_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("rst", 0, 0, 0, 0);
    check_val("rst_valid", int'(bus.sample_valid), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;

    // Channel 0, cnt=0: only the second operator, doubled.
    write_op(0, 100); write_op(3, 200); write_reg(8'hC0, 8'h30);
    run_sample(lat);
    check_val("basic_latency", lat, LAT);
    check_out("basic", 400, 400, 0, 0);
    @(posedge clk); #1;
    check_val("basic_pulse_width", int'(bus.sample_valid), 0);
    check_val("basic_busy_after", int'(bus.busy), 0);

    write_reg(8'hC0, 8'h11);
    run_sample(lat);
    check_val("cnt_latency", lat, LAT);
    check_out("cnt_left", 600, 0, 0, 0);

    fill_ops(4095); fill_regs(8'h31);
    run_sample(lat);
    check_out("pos_clamp", 32767, 32767, 1, 1);

    fill_ops(-4096);
    run_sample(lat);
    check_out("neg_clamp", -32768, -32768, 1, 1);

    fill_ops(0); fill_regs(8'h30);
    write_op(12, 100); write_op(15, 50); write_reg(8'hBD, 8'h20);
    run_sample(lat);
`ifdef OPL_MIXER_RHYTHM_EN
    rh_l = 200; rh_r = 200;
`else
    rh_l = 100; rh_r = 100;
`endif
    check_out("rhythm", rh_l, rh_r, 0, 0);
    write_reg(8'hBD, 8'h00);

    // Same-cycle ops_done and sample_clk_en: the start is dropped.
    @(posedge clk); #1;
    bus.ops_done_pulse = 1'b1; bus.sample_clk_en = 1'b1;
    @(posedge clk); #1;
    bus.ops_done_pulse = 1'b0; bus.sample_clk_en = 1'b0;
    check_val("start_vs_clk_en_busy", int'(bus.busy), 0);

    write_op(12, 0); write_op(15, 0); write_op(0, 100); write_op(3, 200);
    pulse_done();
    repeat (9) @(posedge clk);
    #1;
    check_val("abort_busy_before", int'(bus.busy), 1);
    bus.sample_clk_en = 1'b1;
    @(posedge clk); #1;
    bus.sample_clk_en = 1'b0;
    check_val("abort_busy", int'(bus.busy), 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.sample_valid) seen = 1;
    end
    check_val("abort_no_valid", seen, 0);
    check_out("abort_hold", rh_l, rh_r, 0, 0);

    run_sample(lat);
    check_val("restart_latency", lat, LAT);
    check_out("restart", 400, 400, 0, 0);

    write_reg(8'hC0, 8'h10);
    pulse_done();
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_out("midrst", 0, 0, 0, 0);
    check_val("midrst_busy", int'(bus.busy), 0);
    check_val("midrst_valid", int'(bus.sample_valid), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    write_op(0, 100); write_op(3, 200);
    run_sample(lat);
    check_val("post_rst_latency", lat, LAT);
    check_out("post_rst_pan", 400, 400, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
